onchip_rom_streamer: RTL and testbench

//  Avalon-MM read master directly upstream of the on-chip ROM's s1 slave port. On a start

---
 rtl/onchip_rom_streamer_pkg.sv | 17 +
 rtl/onchip_rom_streamer_fifo.sv | 58 +++++
 rtl/onchip_rom_streamer.sv | 134 +++++++++++++
 tb/tb_onchip_rom_streamer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_rom_streamer_pkg.sv
// Shared definitions for the on-chip ROM streamer and its ROM wrapper.
// The ROM geometry constants here are the single source for both sides.
package onchip_rom_streamer_pkg;

  localparam int ROM_ADDR_W        = 12;
  localparam int ROM_DATA_W        = 32;
  localparam int ROM_DEPTH         = 2560;
  localparam int STREAM_LEN_W      = 12;
  localparam int STREAM_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/onchip_rom_streamer_fifo.sv
// Synchronous first-word-fall-through FIFO for the ROM stream; the head
// entry is always presented on head_data_o while count_o is non-zero.
module rom_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/onchip_rom_streamer.sv
// Avalon-MM read master for the on-chip ROM: fetches a block of words and
// streams them out, issuing a read only when the output buffer can absorb it.
module onchip_rom_streamer
  import onchip_rom_streamer_pkg::*;
#(
  parameter int ADDR_W     = ROM_ADDR_W,
  parameter int DATA_W     = ROM_DATA_W,
  parameter int ROM_WORDS  = ROM_DEPTH,
  parameter int LEN_W      = STREAM_LEN_W,
  parameter int FIFO_DEPTH = STREAM_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_chipselect,
  output logic              rom_clken,
  output logic              rom_write,
  input  logic [DATA_W-1:0] rom_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               inflight_q;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_pop;
  logic               issue;
  logic               credit_ok;
  logic               range_ok;
  logic [SUM_W-1:0]   end_sum;

  // Widened sum so a block ending exactly at the top of the ROM is accepted.
  assign end_sum   = SUM_W'(base_addr) + SUM_W'(length);
  assign range_ok  = (end_sum <= SUM_W'(ROM_WORDS));
  assign credit_ok = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(FIFO_DEPTH);
  assign issue     = (state_q == FETCH) && (remain_q != '0) && credit_ok;
  assign fifo_pop  = st_valid && st_ready;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else if (!range_ok) begin
            err_d = 1'b1;
          end else begin
            state_d  = FETCH;
            addr_d   = base_addr;
            remain_d = length;
          end
        end
      end
      FETCH: begin
        // The final read leaves the address parked on the last word fetched.
        if (issue) begin
          remain_d = remain_q - 1'b1;
          if (remain_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && (fifo_count == CNT_W'(1)) && fifo_pop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      done_q     <= done_d;
      err_q      <= err_d;
      inflight_q <= issue;
    end
  end

  rom_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (inflight_q),
    .push_data_i (rom_readdata),
    .pop_i       (fifo_pop),
    .head_data_o (st_data),
    .count_o     (fifo_count)
  );

  assign st_valid       = (fifo_count != '0);
  assign rom_address    = addr_q;
  assign rom_chipselect = issue;
  assign rom_clken      = issue;
  assign rom_write      = 1'b0;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_onchip_rom_streamer.sv
// Scoreboard bench for onchip_rom_streamer with a 1-cycle-latency ROM model
// whose word i holds 32'hA5000000 + i.
module tb_onchip_rom_streamer;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done, err;
  logic [AW-1:0] rom_address;
  logic          rom_chipselect, rom_clken, rom_write;
  logic [DW-1:0] rom_readdata;
  logic [DW-1:0] st_data;
  logic          st_valid;
  logic          st_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] expQ[$];
  int cycleCnt = 0;
  int doneCount = 0, errCount = 0, csCount = 0;
  int acceptCount = 0, issuedCount = 0, maxOutstanding = 0, badAddrCount = 0;
  int firstCyc = -1, lastCyc = 0, startCyc = 0;
  logic [DW-1:0] lastData = '0;
  int readyMode = 0;
  logic [DW-1:0] romQ = '0;

  onchip_rom_streamer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .rom_address    (rom_address),
    .rom_chipselect (rom_chipselect),
    .rom_clken      (rom_clken),
    .rom_write      (rom_write),
    .rom_readdata   (rom_readdata),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  always @(posedge clk) begin
    if (rom_chipselect && rom_clken) romQ <= 32'hA5000000 + 32'(rom_address);
  end
  assign rom_readdata = romQ;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word and tallies pulses.
  always @(negedge clk) begin
    logic [DW-1:0] expWord;
    if (reset_n) begin
      checkOutput("clken_follows_cs", rom_clken, rom_chipselect);
      checkOutput("rom_write_low", rom_write, 1'b0);
      if (rom_chipselect) begin
        csCount++;
        issuedCount++;
        if (rom_address >= AW'(2560)) badAddrCount++;
      end
      if (done) doneCount++;
      if (err) errCount++;
      if (st_valid && st_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_word", st_data, 64'hFFFFFFFFFFFFFFFF);
        end else begin
          expWord = expQ.pop_front();
          checkOutput("stream_data", st_data, expWord);
        end
        if (firstCyc < 0) firstCyc = cycleCnt;
        lastCyc  = cycleCnt;
        lastData = st_data;
        acceptCount++;
      end
      if (issuedCount - acceptCount > maxOutstanding) maxOutstanding = issuedCount - acceptCount;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (readyMode == 0) st_ready = 1'b1;
      else st_ready = ($urandom_range(0, 99) < 30);
    end
  end

  task automatic clearStats();
    acceptCount    = 0;
    issuedCount    = 0;
    maxOutstanding = 0;
    firstCyc       = -1;
  endtask

  task automatic applyStimulus(input int b, input int l);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(b);
    length    = LW'(l);
    if (l != 0 && b + l <= 2560) begin
      for (int i = 0; i < l; i++) expQ.push_back(32'hA5000000 + 32'(b + i));
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    startCyc = cycleCnt;
  endtask

  task automatic pulseIgnoredStart(input int b, input int l);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(b);
    length    = LW'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((busy || expQ.size() != 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_finished_in_time"}, (n < 3000), 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0, e0, c0, n;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_err", err, 1'b0);
    checkOutput("reset_cs", rom_chipselect, 1'b0);
    checkOutput("reset_clken", rom_clken, 1'b0);
    checkOutput("reset_addr", rom_address, 0);
    checkOutput("reset_st_valid", st_valid, 1'b0);
    reset_n = 1'b1;

    $display("[TB] test 1: base 0 len 8, ready held high");
    clearStats();
    d0 = doneCount;
    applyStimulus(0, 8);
    checkOutput("t1_busy_after_start", busy, 1'b1);
    waitIdle("t1");
    checkOutput("t1_first_latency", 64'(firstCyc - startCyc), 2);
    checkOutput("t1_back_to_back", 64'(lastCyc - firstCyc), 7);
    checkOutput("t1_words", 64'(acceptCount), 8);
    checkOutput("t1_done_pulses", 64'(doneCount - d0), 1);
    checkOutput("t1_last_word", lastData, 32'hA5000007);

    $display("[TB] test 2: range boundary");
    clearStats();
    d0 = doneCount;
    applyStimulus(2552, 8);
    waitIdle("t2a");
    checkOutput("t2a_words", 64'(acceptCount), 8);
    checkOutput("t2a_last_word", lastData, 32'hA50009FF);
    checkOutput("t2a_done_pulses", 64'(doneCount - d0), 1);
    clearStats();
    c0 = csCount;
    e0 = errCount;
    d0 = doneCount;
    applyStimulus(2553, 8);
    checkOutput("t2b_err_pulse", err, 1'b1);
    checkOutput("t2b_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("t2b_err_one_cycle", err, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t2b_no_reads", 64'(csCount - c0), 0);
    checkOutput("t2b_err_count", 64'(errCount - e0), 1);
    checkOutput("t2b_no_done", 64'(doneCount - d0), 0);

    $display("[TB] test 3: zero length");
    c0 = csCount;
    d0 = doneCount;
    applyStimulus(5, 0);
    checkOutput("t3_done_pulse", done, 1'b1);
    checkOutput("t3_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("t3_done_one_cycle", done, 1'b0);
    checkOutput("t3_busy_later", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t3_no_reads", 64'(csCount - c0), 0);
    checkOutput("t3_done_count", 64'(doneCount - d0), 1);

    $display("[TB] test 4: base 16 len 20, random backpressure");
    clearStats();
    d0 = doneCount;
    readyMode = 1;
    applyStimulus(16, 20);
    waitIdle("t4");
    readyMode = 0;
    checkOutput("t4_words", 64'(acceptCount), 20);
    checkOutput("t4_last_word", lastData, 32'hA5000023);
    checkOutput("t4_buffer_bound", (maxOutstanding <= 4), 1'b1);
    checkOutput("t4_done_pulses", 64'(doneCount - d0), 1);

    $display("[TB] test 5: start while busy is dropped");
    clearStats();
    d0 = doneCount;
    e0 = errCount;
    applyStimulus(200, 12);
    repeat (3) @(posedge clk);
    #1;
    pulseIgnoredStart(100, 4);
    checkOutput("t5_still_busy", busy, 1'b1);
    checkOutput("t5_no_err", err, 1'b0);
    waitIdle("t5");
    checkOutput("t5_words", 64'(acceptCount), 12);
    checkOutput("t5_last_word", lastData, 32'hA50000D3);
    checkOutput("t5_done_pulses", 64'(doneCount - d0), 1);
    checkOutput("t5_err_count", 64'(errCount - e0), 0);

    $display("[TB] test 6: reset mid-transfer");
    clearStats();
    d0 = doneCount;
    applyStimulus(40, 10);
    n = 0;
    while (acceptCount < 5 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("t6_words_before_reset", 64'(acceptCount), 5);
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_busy", busy, 1'b0);
    checkOutput("t6_rst_done", done, 1'b0);
    checkOutput("t6_rst_err", err, 1'b0);
    checkOutput("t6_rst_cs", rom_chipselect, 1'b0);
    checkOutput("t6_rst_clken", rom_clken, 1'b0);
    checkOutput("t6_rst_addr", rom_address, 0);
    checkOutput("t6_rst_st_valid", st_valid, 1'b0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    clearStats();
    applyStimulus(300, 3);
    waitIdle("t6");
    checkOutput("t6_words_after", 64'(acceptCount), 3);
    checkOutput("t6_last_word", lastData, 32'hA500012E);
    checkOutput("t6_done_pulses", 64'(doneCount - d0), 1);

    checkOutput("no_out_of_range_reads", 64'(badAddrCount), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
